// File: rtl/banco_registros.sv
// Two-read/one-write register file: 32 x DATA_W, register 0 hard-wired to zero, registered reads.
// Optional macro BANCO_BYPASS_EN: a read of the address being written on the same edge returns DI.
module banco_registros #(
  parameter int DATA_W = 32,
  parameter int N_REG  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              WE,
  input  logic [4:0]        DW,
  input  logic [DATA_W-1:0] DI,
  input  logic [4:0]        RA1,
  input  logic [4:0]        RA2,
  output logic [DATA_W-1:0] DR1,
  output logic [DATA_W-1:0] DR2,
  output logic [15:0]       WCNT
);

  logic [DATA_W-1:0] regs_q [N_REG];
  logic [DATA_W-1:0] dr1_q, dr1_d;
  logic [DATA_W-1:0] dr2_q, dr2_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic              wr_commit;

  // Writes to address 0 are dropped here, so regs_q[0] never leaves its reset value.
  assign wr_commit = WE && (DW != 5'd0);
  assign wcnt_d    = wcnt_q + 16'd1;

  function automatic logic [DATA_W-1:0] rd_sel(input logic [4:0] ra,
                                               input logic [DATA_W-1:0] cur);
    if (ra == 5'd0) return '0;
`ifdef BANCO_BYPASS_EN
    if (wr_commit && (DW == ra)) return DI;
`endif
    return cur;
  endfunction

  always_comb begin
    dr1_d = rd_sel(RA1, regs_q[RA1]);
    dr2_d = rd_sel(RA2, regs_q[RA2]);
  end

  // Reset clears data as well as control: software relies on every register reading 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REG; i++) regs_q[i] <= '0;
      dr1_q  <= '0;
      dr2_q  <= '0;
      wcnt_q <= '0;
    end else begin
      if (wr_commit) begin
        regs_q[DW] <= DI;
        wcnt_q     <= wcnt_d;
      end
      dr1_q <= dr1_d;
      dr2_q <= dr2_d;
    end
  end

  assign DR1  = dr1_q;
  assign DR2  = dr2_q;
  assign WCNT = wcnt_q;

endmodule

// File: doc/banco_registros.md
BANCO_REGISTROS -- requirements
Module: banco_registros

Interface
REQ-001 Parameter DATA_W, default 32: register and data-port width in bits.
REQ-002 Parameter N_REG, default 32: number of registers, addressed by 5-bit fields; fixed at 32 for this datapath.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 WE  input  1: write enable for the write port.
REQ-006 DW  input  5: write address, driven by the upstream write-address mux.
REQ-007 DI  input  DATA_W: write data.
REQ-008 RA1  input  5: read address, port 1.
REQ-009 RA2  input  5: read address, port 2.
REQ-010 DR1  output  DATA_W: registered read data, port 1.
REQ-011 DR2  output  DATA_W: registered read data, port 2.
REQ-012 WCNT  output  16: count of committed writes since reset.

Function
REQ-013 SHALL hold N_REG registers of DATA_W bits; register 0 reads as 0 at all times.
REQ-014 Write: at rising clk with WE=1 and DW!=0, reg[DW] <= DI; WE=1 with DW=0 is discarded.
REQ-015 Read latency: 1 cycle; DR1/DR2 load at rising clk from RA1/RA2 sampled that edge.
REQ-016 RA=0 -> DRx <= 0 in the same cycle, independent of WE/DW.
REQ-017 RA1=RA2: both ports return identical data in the same cycle.
REQ-018 WCNT increments by 1 per committed write (WE=1, DW!=0); wraps 0xFFFF -> 0x0000; no saturation.
REQ-019 WE=0: no register or WCNT change; reads still update each cycle.
REQ-020 X/undefined DW with WE=0 SHALL have no effect on state.

Reset
REQ-021 rst_n=0 SHALL immediately (without clk) clear all registers, DR1, DR2 and WCNT to 0.
REQ-022 Reset asserted mid-write SHALL win: register content after release is 0.
REQ-023 First write accepted at first rising clk with rst_n=1; release is synchronised externally.

Configuration
REQ-024 Macro BANCO_BYPASS_EN defined: same-edge read of the address being written (WE=1, DW=RAx, DW!=0) SHALL return DI (write-through).
REQ-025 BANCO_BYPASS_EN undefined: such a read returns the pre-write register value; new value visible the following cycle.

Verification
REQ-026 rst_n=0 during any activity -> DR1=DR2=0, WCNT=0 immediately; every register reads 0 after release.
REQ-027 WE=1, DW=5, DI=0xDEADBEEF; next cycle RA1=5 -> DR1=0xDEADBEEF one cycle later, WCNT=1.
REQ-028 WE=1, DW=0, DI=0x12345678; RA1=0 -> DR1=0, WCNT unchanged.
REQ-029 reg[7]=0x11; WE=1, DW=7, DI=0x22, RA2=7 same edge -> DR2=0x22 with BANCO_BYPASS_EN, 0x11 without; next cycle 0x22 both builds.
REQ-030 0x10000 committed writes -> WCNT=0x0000; one more -> 0x0001.
REQ-031 RA1=RA2=3 with reg[3]=0xA5A5A5A5 -> DR1=DR2=0xA5A5A5A5 same cycle.
